// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle controller and the datapath muxes it
// steers: state encoding, opcode values, ALUOp codes and mux select codes.
// Contents:
//   state_t                 controller state encoding (S_RST .. S_ERR)
//   OP_*                    opcode field values (IROut[31:26])
//   ALU_*                   ALUOp codes seen by the ALU control
//   SRCB_* / PCSRC_*        ALUSrcB and PCSource select codes
//   is_mem_wait_state()     states that wait on a memory handshake
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RST,
      S_FETCH,
      S_DECODE,
      S_EX_R,
      S_WB_R,
      S_EX_I,
      S_WB_I,
      S_MEM_ADDR,
      S_MEM_RD,
      S_WB_MEM,
      S_MEM_WR,
      S_BR,
      S_JMP,
      S_HALT,
      S_ERR
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_RTYPE = 3'd2;

   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_ONE     = 2'b01;
   localparam logic [1:0] SRCB_SIGNEXT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that hold a memory access open and are covered by the watchdog.
   function automatic logic is_mem_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Memory handshake between the controller and the instruction/data memory.
// Signals:
//   mem_req    controller -> memory  access in progress
//   mem_ready  memory -> controller  access completes this cycle
// Modports: master (controller side), slave (memory side).
interface multicycle_control_fsm_if;

   logic mem_req;
   logic mem_ready;

   modport master (output mem_req, input mem_ready);
   modport slave  (input mem_req, output mem_ready);

endinterface

// File: rtl/multicycle_control_fsm_watchdog.sv
// mem_wait_watchdog: counts consecutive not-ready cycles of one memory access
// and flags expiry when MAX_WAIT cycles have been waited and ready is still low.
// Ports:
//   clk     clock
//   reset   synchronous active-low reset
//   en      controller is in a memory wait state
//   ready   memory completes the access this cycle
//   clear   controller leaves the current state this cycle
//   expire  wait budget exhausted with ready still low
module mem_wait_watchdog #(
   parameter int MAX_WAIT   = 16,
   parameter int WAIT_WIDTH = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic ready,
   input  logic clear,
   output logic expire
);

   logic [WAIT_WIDTH-1:0] count_reg;
   logic [WAIT_WIDTH-1:0] count_next;

   // Ready wins over expiry: a completion on the limit cycle is a normal one.
   assign expire = en && !ready && (count_reg == WAIT_WIDTH'(MAX_WAIT));

   always_comb begin
      count_next = count_reg;
      if (!en || ready || clear) begin
         count_next = '0;
      end else begin
         count_next = count_reg + WAIT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: control unit for the multicycle datapath with a
// variable-latency memory handshake, per-access wait watchdog, HALT and
// illegal-opcode handling, and a saturating retired-instruction counter.
// Ports:
//   clk, reset         clock; synchronous active-low reset
//   opcode             IROut[31:26]
//   alu_zero           ALU zero flag (the datapath gates PCWriteCond with it)
//   mem                memory handshake (master modport: mem_req / mem_ready)
//   PCWriteCond .. RegDst   datapath control bundle
//   retire             pulse on the last cycle of each completed instruction
//   illegal            pulse in DECODE on an undefined opcode
//   halted, mem_err    sticky HALT / watchdog-expiry status
//   instr_count        retired instructions, saturating
module multicycle_control_fsm
   import multicycle_ctrl_pkg::*;
#(
   parameter int OP_WIDTH    = 6,
   parameter int ALUOP_WIDTH = 3,
   parameter int MAX_WAIT    = 16,
   parameter int WAIT_WIDTH  = 5,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [OP_WIDTH-1:0]    opcode,
   input  logic                   alu_zero,
   multicycle_control_fsm_if.master mem,
   output logic                   PCWriteCond,
   output logic                   PCWrite,
   output logic                   IorD,
   output logic                   MemRead,
   output logic                   MemWrite,
   output logic                   MemtoReg,
   output logic                   IRWrite,
   output logic [1:0]             PCSource,
   output logic [ALUOP_WIDTH-1:0] ALUOp,
   output logic [1:0]             ALUSrcB,
   output logic                   ALUSrcA,
   output logic                   RegWrite,
   output logic                   RegDst,
   output logic                   retire,
   output logic                   illegal,
   output logic                   halted,
   output logic                   mem_err,
   output logic [CNT_WIDTH-1:0]   instr_count
);

   state_t                 state_reg;
   state_t                 state_next;
   logic [CNT_WIDTH-1:0]   instr_count_reg;
   logic                   halted_reg;
   logic                   mem_err_reg;
   logic                   halt_retired_reg;
   logic                   mem_req_c;
   logic                   retire_c;
   logic                   wd_en;
   logic                   wd_clear;
   logic                   wd_expire;
   logic                   unused_alu_zero;

   // The branch decision is made in the datapath (PCWriteCond & alu_zero);
   // the flag is kept on the port list so this block drops in for the old one.
   assign unused_alu_zero = alu_zero;

   assign wd_en    = is_mem_wait_state(state_reg);
   assign wd_clear = (state_next != state_reg);

   mem_wait_watchdog #(
      .MAX_WAIT   (MAX_WAIT),
      .WAIT_WIDTH (WAIT_WIDTH)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .en     (wd_en),
      .ready  (mem.mem_ready),
      .clear  (wd_clear),
      .expire (wd_expire)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg        <= S_RST;
         instr_count_reg  <= '0;
         halted_reg       <= 1'b0;
         mem_err_reg      <= 1'b0;
         halt_retired_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (retire_c && (instr_count_reg != {CNT_WIDTH{1'b1}})) begin
            instr_count_reg <= instr_count_reg + CNT_WIDTH'(1);
         end
         if (state_next == S_HALT) begin
            halted_reg <= 1'b1;
         end
         if (state_next == S_ERR) begin
            mem_err_reg <= 1'b1;
         end
         // HALT counts as retired exactly once, on its first cycle.
         if (state_reg == S_HALT) begin
            halt_retired_reg <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      mem_req_c   = 1'b0;
      PCWriteCond = 1'b0;
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      PCSource    = PCSRC_ALU;
      ALUOp       = ALUOP_WIDTH'(ALU_ADD);
      ALUSrcB     = SRCB_REGB;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      retire_c    = 1'b0;
      illegal     = 1'b0;

      case (state_reg)
         S_RST: begin
            state_next = S_FETCH;
         end
         S_FETCH: begin
            mem_req_c = 1'b1;
            MemRead   = 1'b1;
            ALUSrcB   = SRCB_ONE;
            // IR load and PC+1 only happen on the cycle the word arrives.
            IRWrite   = mem.mem_ready;
            PCWrite   = mem.mem_ready;
            if (mem.mem_ready) begin
               state_next = S_DECODE;
            end else if (wd_expire) begin
               state_next = S_ERR;
            end
         end
         S_DECODE: begin
            // Branch target is precomputed into the ALU register here.
            ALUSrcB = SRCB_SIGNEXT;
            case (opcode)
               OP_WIDTH'(OP_RTYPE): state_next = S_EX_R;
               OP_WIDTH'(OP_LW),
               OP_WIDTH'(OP_SW):    state_next = S_MEM_ADDR;
               OP_WIDTH'(OP_BEQ):   state_next = S_BR;
               OP_WIDTH'(OP_J):     state_next = S_JMP;
               OP_WIDTH'(OP_ADDI):  state_next = S_EX_I;
               OP_WIDTH'(OP_HALT):  state_next = S_HALT;
               default: begin
                  illegal    = 1'b1;
                  state_next = S_FETCH;
               end
            endcase
         end
         S_EX_R: begin
            ALUSrcA    = 1'b1;
            ALUOp      = ALUOP_WIDTH'(ALU_RTYPE);
            state_next = S_WB_R;
         end
         S_WB_R: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            retire_c   = 1'b1;
            state_next = S_FETCH;
         end
         S_EX_I: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_SIGNEXT;
            state_next = S_WB_I;
         end
         S_WB_I: begin
            RegWrite   = 1'b1;
            retire_c   = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_ADDR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_SIGNEXT;
            state_next = (opcode == OP_WIDTH'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_req_c = 1'b1;
            MemRead   = 1'b1;
            IorD      = 1'b1;
            if (mem.mem_ready) begin
               state_next = S_WB_MEM;
            end else if (wd_expire) begin
               state_next = S_ERR;
            end
         end
         S_WB_MEM: begin
            MemtoReg   = 1'b1;
            RegWrite   = mem.mem_ready;
            retire_c   = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req_c = 1'b1;
            IorD      = 1'b1;
            MemWrite  = mem.mem_ready;
            retire_c  = mem.mem_ready;
            if (mem.mem_ready) begin
               state_next = S_FETCH;
            end else if (wd_expire) begin
               state_next = S_ERR;
            end
         end
         S_BR: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_WIDTH'(ALU_SUB);
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            retire_c    = 1'b1;
            state_next  = S_FETCH;
         end
         S_JMP: begin
            PCWrite    = 1'b1;
            PCSource   = PCSRC_JUMP;
            retire_c   = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT: begin
            retire_c = !halt_retired_reg;
         end
         S_ERR: begin
            state_next = S_ERR;
         end
         default: begin
            state_next = S_RST;
         end
      endcase
   end

   assign mem.mem_req = mem_req_c;
   assign retire      = retire_c;
   assign halted      = halted_reg;
   assign mem_err     = mem_err_reg;
   assign instr_count = instr_count_reg;

endmodule
